seq_shift_add_multiplier: RTL
=============================

// Module: seq_shift_add_multiplier
// PURPOSE
//   Unsigned sequential shift-add multiplier that drives the datapath ripple-carry adder (RCAdder).
//   Each iteration presents one operand pair on add_a/add_b and consumes add_result.
//   Sits between the operand registers and the adder; produces a double-width product for the MUL path.
//   One iteration per clock; the adder is purely combinational, so its result is consumed in the same cycle.
// PARAMETERS
//   WIDTH  8  operand width; must equal the adder width. Product is 2*WIDTH bits.
// PORTS
//   clock       in   1        system clock; all state updates on rising edge
//   clear       in   1        synchronous active-high reset
//   start       in   1        request a multiply; sampled only in IDLE
//   mplr        in   WIDTH    multiplier operand; captured when start is accepted
//   mcand       in   WIDTH    multiplicand operand; captured when start is accepted
//   add_a       out  WIDTH    adder operand A = ACC register
//   add_b       out  WIDTH    adder operand B = Q[0] ? M : 0
//   add_result  in   WIDTH    adder sum (no carry-out provided)
//   busy        out  1        high whenever state != IDLE
//   done        out  1        one-cycle pulse; product valid
//   product     out  2*WIDTH  registered {ACC,Q}; held until the next accepted start
// BEHAVIOUR
//   - Clock and reset: one clock (clock). Reset (clear) is synchronous and active-high.
//   - Reset value when clear=1 at an edge:
//       state=IDLE; ACC, Q, M, count = 0; product=0; busy=0; done=0; add_a=0; add_b=0.
//     clear overrides start and any in-flight operation; the partial result is discarded.
//   - States:
//       IDLE -> RUN on start.
//       RUN -> RUN while count < WIDTH-1.
//       RUN -> DONE on the iteration where count == WIDTH-1.
//       DONE -> IDLE unconditionally.
//   - Accept (IDLE && start at edge k): ACC<=0, Q<=mplr, M<=mcand, count<=0, state<=RUN.
//   - start is ignored in RUN and in DONE. No queuing: the request is dropped.
//   - RUN iteration (edges k+1 .. k+WIDTH):
//       sum = add_result
//       c   = (a[W-1]&b[W-1]) | ((a[W-1]|b[W-1]) & ~sum[W-1])   (carry-out derived from MSBs)
//       ACC <= {c, sum[W-1:1]}; Q <= {sum[0], Q[W-1:1]}; count <= count+1
//   - When Q[0]=0, add_b=0, so the formula gives c=0 and ACC shifts right with 0 inserted.
//   - At edge k+WIDTH: product <= final {ACC,Q}; state <= DONE.
//   - In the cycle after edge k+WIDTH: done=1, busy=1. The next edge returns to IDLE (done=0).
//   - Latency: start sampled at edge k -> done high during cycle k+WIDTH .. k+WIDTH+1.
//     Earliest next accepted start is at edge k+WIDTH+2.
//   - Back-to-back: start held high is accepted again in the first IDLE cycle after DONE.
//   - Arithmetic: unsigned only; the product never overflows 2*WIDTH bits.
//   - No internal wrap; count width = clog2(WIDTH)+1.
//   - add_a/add_b are combinational from registers and are meaningful only in RUN.
//     In IDLE/DONE they reflect the stale ACC/M/Q state; the adder output is ignored there.
//   - Operand inputs changing after the accept edge have no effect on the current operation.
// TESTING
//   Bench instantiates RCAdder plus this block, with add_a/add_b/add_result wired to the adder.
//   1. Basic products (one case per run):
//        mplr=42,  mcand=58  -> product=2436  (16'h0984), done pulse exactly once, busy high for 9 cycles.
//        mplr=105, mcand=21  -> product=2205  (16'h089D).
//   2. Carry path: mplr=255, mcand=255 -> product=65025 (16'hFE01).
//        mplr=128, mcand=255 -> 32640 (16'h7F80).
//   3. Zeros: mplr=0, mcand=200 -> 0; mplr=200, mcand=0 -> 0; done still asserted at the same latency.
//   4. Start while busy: second start with 3x3 at edges k+2 and k+9 (during DONE) is ignored.
//        First result is unchanged; a later start in IDLE yields 9.
//   5. Mid-run reset: clear=1 at edge k+4 -> next cycle busy=0, done=0, product=0.
//        A new start 6x7 then yields 42 with normal latency.
//   6. Latency/hold: with start held high continuously, done pulses every WIDTH+2 cycles.
//        product holds its value in IDLE while operand inputs toggle.

Source files
------------

// File: rtl/seq_shift_add_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_add_multiplier_if
// Description : Request/adder/result bundle between a multiplier client,
//               the external combinational adder and the multiplier core.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_shift_add_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     mplr;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     add_a;
    logic [WIDTH-1:0]     add_b;
    logic [WIDTH-1:0]     add_result;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    // Client side; it also closes the adder loop (add_a/add_b -> add_result).
    modport master (
        output start,
        output mplr,
        output mcand,
        output add_result,
        input  add_a,
        input  add_b,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  mplr,
        input  mcand,
        input  add_result,
        output add_a,
        output add_b,
        output busy,
        output done,
        output product
    );
endinterface
`default_nettype wire

// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_add_multiplier
// Description : Unsigned shift-add multiplier, one iteration per clock,
//               using an external combinational adder; 2*WIDTH-bit product.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  wire logic                   clock,
    input  wire logic                   clear,
    seq_shift_add_multiplier_if.slave   bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0]    c_IDLE = 2'd0;
    localparam logic [1:0]    c_RUN  = 2'd1;
    localparam logic [1:0]    c_DONE = 2'd2;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_m;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_add_a;
    logic [WIDTH-1:0]   w_add_b;
    logic [WIDTH-1:0]   w_sum;
    logic               w_carry;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               w_last;

    assign w_add_a = r_acc;
    assign w_add_b = r_q[0] ? r_m : '0;
    assign w_sum   = bus.add_result;

    // The adder has no carry-out, so rebuild it from the operand and sum MSBs.
    assign w_carry = (w_add_a[WIDTH-1] & w_add_b[WIDTH-1])
                   | ((w_add_a[WIDTH-1] | w_add_b[WIDTH-1]) & ~w_sum[WIDTH-1]);

    assign w_acc_nxt = {w_carry, w_sum[WIDTH-1:1]};
    assign w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
    assign w_last    = (r_count == c_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (bus.start) w_state_nxt = c_RUN;
            c_RUN:   if (w_last)    w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy    = (r_state != c_IDLE);
        bus.done    = (r_state == c_DONE);
        bus.add_a   = w_add_a;
        bus.add_b   = w_add_b;
        bus.product = r_product;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            r_acc     <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_acc   <= '0;
                        r_q     <= bus.mplr;
                        r_m     <= bus.mcand;
                        r_count <= '0;
                    end
                end
                c_RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_q     <= w_q_nxt;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_product <= {w_acc_nxt, w_q_nxt};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
